mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/mem_byte_merge.sv | 13 +
 rtl/mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM encoding and byte-strobe constants.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IF_RD = 3'd1,
    ST_D_RD  = 3'd2,
    ST_D_RMW = 3'd3,
    ST_D_WR  = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  localparam logic [3:0] STRB_WORD = 4'b1111;
  localparam logic [3:0] STRB_NONE = 4'b0000;

endpackage

// File: rtl/mem_byte_merge.sv
// Combinational byte-lane merge: strobed lanes come from new_word, the rest from old_word.
module mem_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  strb,
  output logic [31:0] merged
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port-per-requester memory controller arbitrating an instruction fetch port and a
// data port (loads, full/partial stores via read-modify-write) onto a 2R/1W word memory.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a new request, data port has priority
// IF_RD    | fetch read on port 1, capture instruction word
// D_RD     | load read on port 2, capture data word
// D_RMW    | partial store: read old word on port 2
// D_WR     | write (full word or merged word)
// RESP     | one-cycle ack to the requester that was accepted
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rdy,
  output logic                  if_ack,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [3:0]            d_strb,
  input  logic [31:0]           d_wdata,
  output logic                  d_rdy,
  output logic                  d_ack,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic [ADDR_WIDTH-3:0] m_raddr1,
  output logic [ADDR_WIDTH-3:0] m_raddr2,
  output logic [ADDR_WIDTH-3:0] m_waddr,
  output logic                  m_rden1,
  output logic                  m_rden2,
  output logic                  m_wren,
  output logic [31:0]           m_wdata,
  input  logic [31:0]           m_rdata1,
  input  logic [31:0]           m_rdata2
);

  state_t state, state_nxt;

  logic [ADDR_WIDTH-3:0] idx_q;
  logic [3:0]            strb_q;
  logic [31:0]           wdata_q;
  logic [31:0]           old_q;
  logic                  err_q;
  logic                  dsel_q;

  logic acc_d, acc_if, err_nxt;
  logic [31:0] merged;

  mem_byte_merge u_merge (
    .old_word (old_q),
    .new_word (wdata_q),
    .strb     (strb_q),
    .merged   (merged)
  );

  always_comb begin
    state_nxt = state;
    acc_d     = 1'b0;
    acc_if    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (d_req) begin
          acc_d = 1'b1;
          if (d_strb == STRB_WORD && d_addr[1:0] != 2'b00) begin
            err_nxt   = 1'b1;
            state_nxt = ST_RESP;
          end else if (!d_wr) begin
            state_nxt = ST_D_RD;
          end else if (d_strb == STRB_NONE) begin
            state_nxt = ST_RESP;
          end else if (d_strb == STRB_WORD) begin
            state_nxt = ST_D_WR;
          end else begin
            state_nxt = ST_D_RMW;
          end
        end else if (if_req) begin
          acc_if    = 1'b1;
          state_nxt = ST_IF_RD;
        end
      end
      ST_IF_RD: state_nxt = ST_RESP;
      ST_D_RD:  state_nxt = ST_RESP;
      ST_D_RMW: state_nxt = ST_D_WR;
      ST_D_WR:  state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx_q    <= '0;
      strb_q   <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      err_q    <= 1'b0;
      dsel_q   <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (acc_d) begin
        idx_q   <= d_addr[ADDR_WIDTH-1:2];
        strb_q  <= d_strb;
        wdata_q <= d_wdata;
        err_q   <= err_nxt;
        dsel_q  <= 1'b1;
      end else if (acc_if) begin
        idx_q  <= if_addr[ADDR_WIDTH-1:2];
        err_q  <= 1'b0;
        dsel_q <= 1'b0;
      end
      if (state == ST_IF_RD) if_rdata <= m_rdata1;
      if (state == ST_D_RD)  d_rdata  <= m_rdata2;
      if (state == ST_D_RMW) old_q    <= m_rdata2;
    end
  end

  assign if_rdy = (state == ST_IDLE);
  assign d_rdy  = (state == ST_IDLE);
  assign if_ack = (state == ST_RESP) && !dsel_q;
  assign d_ack  = (state == ST_RESP) && dsel_q;
  assign d_err  = (state == ST_RESP) && dsel_q && err_q;

  assign m_rden1  = (state == ST_IF_RD);
  assign m_rden2  = (state == ST_D_RD) || (state == ST_D_RMW);
  assign m_wren   = (state == ST_D_WR);
  assign m_raddr1 = idx_q;
  assign m_raddr2 = idx_q;
  assign m_waddr  = idx_q;
  // Full-word stores pass straight through the merge since every lane is strobed.
  assign m_wdata  = merged;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios then randomized traffic against a
// transaction-level memory model.
module tb_mem_ctrl;

  localparam int AW = 10;
  localparam int NW = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [3:0]    d_strb = '0;
  logic [31:0]   d_wdata = '0;
  logic          if_rdy, if_ack, d_rdy, d_ack, d_err;
  logic [31:0]   if_rdata, d_rdata;
  logic [AW-3:0] m_raddr1, m_raddr2, m_waddr;
  logic          m_rden1, m_rden2, m_wren;
  logic [31:0]   m_wdata, m_rdata1, m_rdata2;

  logic [31:0] mem     [NW];
  logic [31:0] ref_mem [NW];
  logic        load_mem = 1'b0;
  logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;

  int n_chk = 0, n_fail = 0;
  int n_wren = 0, n_rden1 = 0, n_rden2 = 0, n_ifack = 0, n_dack = 0, n_b2b = 0;
  logic prev_ack = 1'b0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_strb(d_strb), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_raddr1(m_raddr1), .m_raddr2(m_raddr2), .m_waddr(m_waddr),
    .m_rden1(m_rden1), .m_rden2(m_rden2), .m_wren(m_wren), .m_wdata(m_wdata),
    .m_rdata1(m_rdata1), .m_rdata2(m_rdata2)
  );

  assign m_rdata1 = mem[m_raddr1];
  assign m_rdata2 = mem[m_raddr2];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < NW; i++) mem[i] <= ref_mem[i];
    end else if (m_wren) begin
      mem[m_waddr] <= m_wdata;
    end
  end

  // Event counters sampled at the rising edge; tasks compare deltas.
  always @(posedge clk) begin
    if (m_wren)  n_wren++;
    if (m_rden1) n_rden1++;
    if (m_rden2) n_rden2++;
    if (if_ack)  n_ifack++;
    if (d_ack)   n_dack++;
    if ((if_ack || d_ack) && prev_ack) n_b2b++;
    prev_ack = if_ack || d_ack;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; expectations come from the model before the DUT is driven.
  task automatic run_op(input bit do_if, input bit do_d, input bit wr,
                        input logic [AW-1:0] ifa, input logic [AW-1:0] da,
                        input logic [3:0] strb, input logic [31:0] wdata);
    int e_lat, lat, e_wren, e_rden1, e_rden2, s_wren, s_rden1, s_rden2, s_ifack, s_dack;
    bit e_err, ack;
    logic [31:0] w;
    int idx;
    e_wren = 0; e_rden1 = 0; e_rden2 = 0; e_err = 0;
    if (do_d) begin
      idx = int'(da[AW-1:2]);
      if (strb == 4'hF && da[1:0] != 2'b00) begin
        e_lat = 1; e_err = 1;
      end else if (!wr) begin
        e_lat = 2; e_rden2 = 1; exp_d_rdata = ref_mem[idx];
      end else if (strb == 4'h0) begin
        e_lat = 1;
      end else if (strb == 4'hF) begin
        e_lat = 2; e_wren = 1; ref_mem[idx] = wdata;
      end else begin
        e_lat = 3; e_wren = 1; e_rden2 = 1;
        w = ref_mem[idx];
        for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
        ref_mem[idx] = w;
      end
    end else begin
      e_lat = 2; e_rden1 = 1; exp_if_rdata = ref_mem[int'(ifa[AW-1:2])];
    end

    @(negedge clk);
    chk("rdy_if", {31'b0, if_rdy}, 32'd1);
    chk("rdy_d", {31'b0, d_rdy}, 32'd1);
    s_wren = n_wren; s_rden1 = n_rden1; s_rden2 = n_rden2; s_ifack = n_ifack; s_dack = n_dack;
    if_req = do_if; if_addr = ifa;
    d_req = do_d; d_wr = wr; d_addr = da; d_strb = strb; d_wdata = wdata;
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    d_wr = 1'($urandom); d_addr = AW'($urandom); if_addr = AW'($urandom);
    d_strb = 4'($urandom); d_wdata = $urandom;
    lat = 1;
    ack = do_d ? d_ack : if_ack;
    while (!ack && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      ack = do_d ? d_ack : if_ack;
    end
    chk("latency", lat, e_lat);
    if (do_d) begin
      chk("d_err", {31'b0, d_err}, {31'b0, e_err});
      chk("d_rdata", d_rdata, exp_d_rdata);
    end else begin
      chk("if_rdata", if_rdata, exp_if_rdata);
    end
    @(posedge clk); #1;
    chk("idle_rdy", {31'b0, d_rdy}, 32'd1);
    chk("n_wren", n_wren - s_wren, e_wren);
    chk("n_rden1", n_rden1 - s_rden1, e_rden1);
    chk("n_rden2", n_rden2 - s_rden2, e_rden2);
    chk("n_ifack", n_ifack - s_ifack, do_d ? 0 : 1);
    chk("n_dack", n_dack - s_dack, do_d ? 1 : 0);
  endtask

  initial begin
    int s_wren, s_dack, kind;
    logic [3:0] strb;
    logic [AW-1:0] a;

    for (int i = 0; i < NW; i++) ref_mem[i] = $urandom;
    ref_mem[3] = 32'h1234_5678;
    ref_mem[5] = 32'hAABB_CCDD;
    load_mem = 1'b1;
    @(posedge clk); #1;
    load_mem = 1'b0;

    chk("rst_if_ack", {31'b0, if_ack}, 32'd0);
    chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
    chk("rst_d_err", {31'b0, d_err}, 32'd0);
    chk("rst_en", {29'b0, m_wren, m_rden1, m_rden2}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_rdy", {30'b0, if_rdy, d_rdy}, 32'd3);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1, 0, 0, 10'd12, '0, '0, '0);
    run_op(0, 1, 1, '0, 10'd16, 4'b1111, 32'hDEAD_BEEF);
    chk("mem4", mem[4], 32'hDEAD_BEEF);
    run_op(0, 1, 1, '0, 10'd20, 4'b0010, 32'h0000_1100);
    chk("mem5", mem[5], 32'hAABB_11DD);
    run_op(1, 1, 0, 10'd40, 10'd12, 4'b1111, '0);
    chk("both_rdata", d_rdata, 32'h1234_5678);
    run_op(1, 0, 0, 10'd12, '0, '0, '0);
    run_op(0, 1, 0, '0, 10'd13, 4'b1111, '0);
    run_op(0, 1, 1, '0, 10'd24, 4'b0000, 32'hFFFF_FFFF);

    // Reset during the write phase of a partial store.
    @(negedge clk);
    s_wren = n_wren; s_dack = n_dack;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 10'd28; d_strb = 4'b0100; d_wdata = 32'h00AB_0000;
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    chk("rmw_in_wr", {31'b0, m_wren}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_kill_wren", {31'b0, m_wren}, 32'd0);
    chk("rst_kill_ack", {31'b0, d_ack}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_rdy", {31'b0, d_rdy}, 32'd1);
    @(posedge clk); #1;
    chk("rel_rdy2", {30'b0, if_rdy, d_rdy}, 32'd3);
    chk("abort_wren", n_wren - s_wren, 32'd0);
    chk("abort_dack", n_dack - s_dack, 32'd0);
    chk("abort_mem7", mem[7], ref_mem[7]);
    exp_d_rdata = '0;
    exp_if_rdata = '0;
    chk("abort_d_rdata", d_rdata, 32'd0);

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       strb = 4'b0000;
        1:       strb = 4'b1111;
        default: strb = 4'($urandom);
      endcase
      a = AW'($urandom);
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      case (kind)
        0:       run_op(1, 0, 0, AW'($urandom), a, strb, $urandom);
        1:       run_op(0, 1, 0, AW'($urandom), a, strb, $urandom);
        2:       run_op(0, 1, 1, AW'($urandom), a, strb, $urandom);
        default: run_op(1, 1, 1'($urandom), AW'($urandom), a, strb, $urandom);
      endcase
    end

    for (int i = 0; i < NW; i++) chk("mem_final", mem[i], ref_mem[i]);
    chk("b2b_ack", n_b2b, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
